// File: rtl/classify_count.sv
// Qubit-readout classification tally: counts excited, ground and on-the-line
// results from the upstream IQ classifier while data_in qualifies each sample.
module classify_count #(
    parameter int unsigned WIDTH    = 16,
    parameter bit          SATURATE = 1'b1
) (
    input  logic             clk100,
    input  logic             reset,
    input  logic             data_in,
    input  logic [1:0]       state,
    output logic [WIDTH-1:0] excited_count,
    output logic [WIDTH-1:0] ground_count,
    output logic [WIDTH-1:0] line_count
);

    typedef enum logic [1:0] {
        CLS_NONE    = 2'b00,
        CLS_GROUND  = 2'b01,
        CLS_EXCITED = 2'b10,
        CLS_LINE    = 2'b11
    } cls_e;

    typedef struct packed {
        logic excited;
        logic ground;
        logic line;
    } inc_t;

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    logic [WIDTH-1:0] excited_q, excited_d;
    logic [WIDTH-1:0] ground_q,  ground_d;
    logic [WIDTH-1:0] line_q,    line_d;
    inc_t             inc;

    function automatic logic [WIDTH-1:0] bump(input logic [WIDTH-1:0] cnt,
                                              input logic             en);
        logic [WIDTH-1:0] nxt;
        nxt = cnt;
        if (en) begin
            if (SATURATE && (cnt == ALL_ONES))
                nxt = cnt;
            else
                nxt = cnt + WIDTH'(1);
        end
        return nxt;
    endfunction

    // NOTE: every signal written here gets a default before the case, and the
    // case carries a default arm; together they rule out an inferred latch and
    // make an X/Z or 2'b00 code select "no increment".
    always_comb begin
        inc = '0;
        if (data_in) begin
            case (state)
                CLS_GROUND:  inc.ground  = 1'b1;
                CLS_EXCITED: inc.excited = 1'b1;
                CLS_LINE:    inc.line    = 1'b1;
                default:     inc         = '0;
            endcase
        end
    end

    always_comb begin
        excited_d = bump(excited_q, inc.excited);
        ground_d  = bump(ground_q,  inc.ground);
        line_d    = bump(line_q,    inc.line);
    end

    // NOTE: state registers use non-blocking assignments so every counter
    // updates from the same pre-edge values.
    always_ff @(posedge clk100 or negedge reset) begin
        if (!reset) begin
            excited_q <= '0;
            ground_q  <= '0;
            line_q    <= '0;
        end else begin
            excited_q <= excited_d;
            ground_q  <= ground_d;
            line_q    <= line_d;
        end
    end

    assign excited_count = excited_q;
    assign ground_count  = ground_q;
    assign line_count    = line_q;

endmodule

// File: tb/tb_classify_count.sv
// Self-checking bench for classify_count: an ideal-count model checked every
// cycle against a 16-bit saturating, 4-bit saturating and 4-bit wrapping DUT.
module tb_classify_count;

    logic       clk100 = 1'b0;
    logic       reset  = 1'b1;
    logic       data_in = 1'b0;
    logic [1:0] state  = 2'b00;

    logic [15:0] exc16, gnd16, lin16;
    logic [3:0]  exc_s4, gnd_s4, lin_s4;
    logic [3:0]  exc_w4, gnd_w4, lin_w4;

    int tests_run = 0;
    int tests_failed = 0;

    // Unbounded counts of valid samples per class: 0 excited, 1 ground, 2 line.
    int ideal [3] = '{0, 0, 0};

    always #5 clk100 = ~clk100;

    classify_count #(.WIDTH(16), .SATURATE(1'b1)) u_dut16 (
        .clk100(clk100), .reset(reset), .data_in(data_in), .state(state),
        .excited_count(exc16), .ground_count(gnd16), .line_count(lin16));

    classify_count #(.WIDTH(4), .SATURATE(1'b1)) u_sat4 (
        .clk100(clk100), .reset(reset), .data_in(data_in), .state(state),
        .excited_count(exc_s4), .ground_count(gnd_s4), .line_count(lin_s4));

    classify_count #(.WIDTH(4), .SATURATE(1'b0)) u_wrap4 (
        .clk100(clk100), .reset(reset), .data_in(data_in), .state(state),
        .excited_count(exc_w4), .ground_count(gnd_w4), .line_count(lin_w4));

    always @(posedge clk100 or negedge reset) begin
        if (!reset) begin
            ideal = '{0, 0, 0};
        end else if (data_in === 1'b1) begin
            if (state === 2'b10) ideal[0] = ideal[0] + 1;
            else if (state === 2'b01) ideal[1] = ideal[1] + 1;
            else if (state === 2'b11) ideal[2] = ideal[2] + 1;
        end
    end

    function automatic int expect_cnt(input int n, input int w, input bit sat);
        int max_v;
        max_v = (1 << w) - 1;
        if (sat) return (n > max_v) ? max_v : n;
        return n % (1 << w);
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Per-cycle compare, sampled 3 ns after each rising edge.
    initial begin
        forever begin
            @(posedge clk100);
            #3;
            check("cmp exc16", int'(exc16),  expect_cnt(ideal[0], 16, 1'b1));
            check("cmp gnd16", int'(gnd16),  expect_cnt(ideal[1], 16, 1'b1));
            check("cmp lin16", int'(lin16),  expect_cnt(ideal[2], 16, 1'b1));
            check("cmp exc_s4", int'(exc_s4), expect_cnt(ideal[0], 4, 1'b1));
            check("cmp gnd_s4", int'(gnd_s4), expect_cnt(ideal[1], 4, 1'b1));
            check("cmp lin_s4", int'(lin_s4), expect_cnt(ideal[2], 4, 1'b1));
            check("cmp exc_w4", int'(exc_w4), expect_cnt(ideal[0], 4, 1'b0));
            check("cmp gnd_w4", int'(gnd_w4), expect_cnt(ideal[1], 4, 1'b0));
            check("cmp lin_w4", int'(lin_w4), expect_cnt(ideal[2], 4, 1'b0));
        end
    end

    // Drive one cycle of inputs on the falling edge.
    task automatic cyc(input logic d, input logic [1:0] s);
        @(negedge clk100);
        data_in = d;
        state   = s;
    endtask

    task automatic check16(input string tag, input int e, input int g, input int l);
        check({tag, " exc"}, int'(exc16), e);
        check({tag, " gnd"}, int'(gnd16), g);
        check({tag, " lin"}, int'(lin16), l);
    endtask

    task automatic do_reset();
        @(negedge clk100);
        reset   = 1'b0;
        data_in = 1'b0;
        @(negedge clk100);
        check16("in reset", 0, 0, 0);
        @(negedge clk100);
        reset = 1'b1;
    endtask

    initial begin
        // Reset held low with an active line strobe must count nothing.
        #1;
        reset   = 1'b0;
        data_in = 1'b1;
        state   = 2'b11;
        repeat (2) @(negedge clk100);
        check16("reset hold", 0, 0, 0);
        reset = 1'b1;
        cyc(1'b0, 2'b00);
        check16("after release", 0, 0, 1);

        // Single-cycle strobes over three batches separated by reset.
        do_reset();
        for (int b = 0; b < 3; b++) begin
            cyc(1'b1, 2'b11); cyc(1'b0, 2'b00);
            cyc(1'b1, 2'b01); cyc(1'b0, 2'b00);
            cyc(1'b1, 2'b10); cyc(1'b0, 2'b00);
            cyc(1'b0, 2'b00);
            check16($sformatf("batch%0d", b), 1, 1, 1);
            do_reset();
        end

        // Held strobe, unclassified code, and idle with a toggling code.
        repeat (5) cyc(1'b1, 2'b01);
        cyc(1'b0, 2'b00);
        check16("held ground", 0, 5, 0);
        repeat (3) cyc(1'b1, 2'b00);
        cyc(1'b0, 2'b00);
        check16("code 00", 0, 5, 0);
        for (int s = 0; s < 4; s++) cyc(1'b0, 2'(s));
        cyc(1'b0, 2'b00);
        check16("idle toggle", 0, 5, 0);

        // Asynchronous reset dropped between clock edges.
        cyc(1'b1, 2'b10);
        cyc(1'b0, 2'b00);
        @(posedge clk100);
        #2;
        reset = 1'b0;
        #1;
        check16("async rst", 0, 0, 0);
        check("async rst gnd_s4", int'(gnd_s4), 0);
        @(negedge clk100);
        reset = 1'b1;

        // Overflow: 20 excited samples.
        repeat (20) cyc(1'b1, 2'b10);
        cyc(1'b0, 2'b00);
        check("ovf sat4 exc", int'(exc_s4), 15);
        check("ovf wrap4 exc", int'(exc_w4), 4);
        check("ovf 16 exc", int'(exc16), 20);
        check("ovf sat4 gnd", int'(gnd_s4), 0);
        check("ovf sat4 lin", int'(lin_s4), 0);
        check("ovf wrap4 gnd", int'(gnd_w4), 0);
        check("ovf wrap4 lin", int'(lin_w4), 0);

        repeat (2) @(negedge clk100);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
